// File: rtl/serial_operand_serializer.sv
// rtl/serial_operand_serializer.sv - parallel operand pair to LSB-first serial bit pairs
// Feeds the serial adder; one operation in flight plus one pending pair for gapless streaming.
module serial_operand_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [WIDTH-1:0] pd_a_q, pd_a_d, pd_b_q, pd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pd_full_q, pd_full_d;
    logic             acc, xfer, last_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            pd_a_q    <= '0;
            pd_b_q    <= '0;
            cnt_q     <= '0;
            pd_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            pd_a_q    <= pd_a_d;
            pd_b_q    <= pd_b_d;
            cnt_q     <= cnt_d;
            pd_full_q <= pd_full_d;
        end
    end

    // in_ready deliberately independent of ser_ready: only the pending slot gates acceptance.
    assign in_ready  = reset && !pd_full_q;
    assign ser_valid = (state_q == SHIFT);
    assign ser_a     = ser_valid && sh_a_q[0];
    assign ser_b     = ser_valid && sh_b_q[0];
    assign ser_first = ser_valid && (cnt_q == '0);
    assign ser_last  = ser_valid && (cnt_q == LAST_IDX);
    assign busy      = (state_q == SHIFT) || pd_full_q;

    assign acc       = in_valid && in_ready;
    assign xfer      = ser_valid && ser_ready;
    assign last_xfer = xfer && ser_last;

    always_comb begin
        state_d   = state_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        pd_a_d    = pd_a_q;
        pd_b_d    = pd_b_q;
        cnt_d     = cnt_q;
        pd_full_d = pd_full_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    sh_a_d  = data_a;
                    sh_b_d  = data_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    cnt_d = '0;
                    if (pd_full_q) begin
                        sh_a_d    = pd_a_q;
                        sh_b_d    = pd_b_q;
                        pd_full_d = 1'b0;
                    end else if (acc) begin
                        sh_a_d = data_a;
                        sh_b_d = data_b;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                        sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                    if (acc) begin
                        pd_a_d    = data_a;
                        pd_b_d    = data_b;
                        pd_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb/tb_serial_operand_serializer.sv - directed self-checking bench for serial_operand_serializer
module tb_serial_operand_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_a = 8'h00;
    logic [7:0] data_b = 8'h00;
    logic       ser_valid;
    logic       ser_ready = 1'b1;
    logic       ser_a, ser_b, ser_first, ser_last, busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    serial_operand_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the serial outputs for bit i of (a, b), then advances one clock.
    task automatic bit_chk(input string tag, input logic [7:0] a, input logic [7:0] b, input int i);
        chk($sformatf("%s_valid_b%0d", tag, i), ser_valid, 1'b1);
        chk($sformatf("%s_a_b%0d", tag, i), ser_a, a[i]);
        chk($sformatf("%s_b_b%0d", tag, i), ser_b, b[i]);
        chk($sformatf("%s_first_b%0d", tag, i), ser_first, (i == 0));
        chk($sformatf("%s_last_b%0d", tag, i), ser_last, (i == 7));
        step();
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        data_a   = a;
        data_b   = b;
        chk("accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_idle_valid"}, ser_valid, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_first", ser_first, 1'b0);
        chk("rst_last", ser_last, 1'b0);
        chk("rst_ser_a", ser_a, 1'b0);
        step();
        step();
        reset = 1'b1;
        #1;
        idle_chk("post_rst");
        step();

        // Single op, no backpressure
        accept(8'h1B, 8'h15);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_in_ready_b%0d", i), in_ready, 1'b1);
            bit_chk("t1", 8'h1B, 8'h15, i);
        end
        idle_chk("t1");

        // Backpressure at bit 2
        accept(8'h1B, 8'h15);
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                ser_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk("t2_hold_valid", ser_valid, 1'b1);
                    chk("t2_hold_a", ser_a, 1'b0);
                    chk("t2_hold_b", ser_b, 1'b1);
                    chk("t2_hold_first", ser_first, 1'b0);
                    step();
                    cyc++;
                end
                ser_ready = 1'b1;
            end
            bit_chk("t2", 8'h1B, 8'h15, i);
            cyc++;
        end
        chk("t2_serial_cycles", cyc, 11);
        idle_chk("t2");

        // Back-to-back with pending op offered at bit 3
        accept(8'h1B, 8'h15);
        for (int i = 0; i < 3; i++) bit_chk("t3op1", 8'h1B, 8'h15, i);
        in_valid = 1'b1;
        data_a   = 8'hFF;
        data_b   = 8'h01;
        chk("t3_offer_ready", in_ready, 1'b1);
        bit_chk("t3op1", 8'h1B, 8'h15, 3);
        in_valid = 1'b0;
        for (int i = 4; i < 8; i++) begin
            chk($sformatf("t3_pend_ready_b%0d", i), in_ready, 1'b0);
            chk($sformatf("t3_pend_busy_b%0d", i), busy, 1'b1);
            bit_chk("t3op1", 8'h1B, 8'h15, i);
        end
        for (int i = 0; i < 8; i++) bit_chk("t3op2", 8'hFF, 8'h01, i);
        idle_chk("t3");

        // Bypass on last-transfer cycle
        accept(8'h1B, 8'h15);
        for (int i = 0; i < 7; i++) bit_chk("t4op1", 8'h1B, 8'h15, i);
        in_valid = 1'b1;
        data_a   = 8'hA5;
        data_b   = 8'h5A;
        chk("t4_bypass_ready", in_ready, 1'b1);
        bit_chk("t4op1", 8'h1B, 8'h15, 7);
        in_valid = 1'b0;
        chk("t4_bypass_no_pend", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) bit_chk("t4op2", 8'hA5, 8'h5A, i);
        idle_chk("t4");

        // Pending full with a third op held on the input
        accept(8'h1B, 8'h15);
        bit_chk("t5op1", 8'h1B, 8'h15, 0);
        in_valid = 1'b1;
        data_a   = 8'hFF;
        data_b   = 8'h01;
        bit_chk("t5op1", 8'h1B, 8'h15, 1);
        data_a   = 8'h3C;
        data_b   = 8'hC3;
        for (int i = 2; i < 8; i++) begin
            chk($sformatf("t5_full_ready_b%0d", i), in_ready, 1'b0);
            bit_chk("t5op1", 8'h1B, 8'h15, i);
        end
        chk("t5_op3_accept_ready", in_ready, 1'b1);
        bit_chk("t5op2", 8'hFF, 8'h01, 0);
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("t5_op3_pend_ready_b%0d", i), in_ready, 1'b0);
            bit_chk("t5op2", 8'hFF, 8'h01, i);
        end
        for (int i = 0; i < 8; i++) bit_chk("t5op3", 8'h3C, 8'hC3, i);
        idle_chk("t5");

        // Asynchronous reset mid-op with pending op present
        accept(8'h1B, 8'h15);
        bit_chk("t6", 8'h1B, 8'h15, 0);
        bit_chk("t6", 8'h1B, 8'h15, 1);
        in_valid = 1'b1;
        data_a   = 8'hFF;
        data_b   = 8'h01;
        bit_chk("t6", 8'h1B, 8'h15, 2);
        in_valid = 1'b0;
        bit_chk("t6", 8'h1B, 8'h15, 3);
        chk("t6_busy_before", busy, 1'b1);
        chk("t6_pend_before", in_ready, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", ser_valid, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_ready", in_ready, 1'b0);
        chk("t6_async_first", ser_first, 1'b0);
        step();
        step();
        reset = 1'b1;
        #1;
        idle_chk("t6_release");
        step();
        idle_chk("t6_release2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
